// File: rtl/mediums_pkg.sv
// Shared types and helpers for the BRAM-backed data/result mediums.
// Both mediums map word addresses onto BRAM piece addresses the same way.
package mediums_pkg;

  typedef enum logic {
    IDLE,
    WRITE
  } medium_wr_state_t;

  // BRAM address of piece 'piece' within word 'addr' (piece 0 = most significant).
  function automatic logic [31:0] piece_addr(input logic [31:0] addr,
                                             input logic [31:0] pieces,
                                             input logic [31:0] piece);
    return addr * pieces + piece;
  endfunction

endpackage

// File: rtl/result_medium.sv
// Result medium: takes one wide word from the CPU and writes it MSB-first as
// PIECES consecutive BRAM_WIDTH-bit pieces on a BRAM write port, one per clock.
module result_medium
  import mediums_pkg::*;
#(
  parameter int ADDRS      = 1024,
  parameter int PIECES     = 32,
  parameter int BRAM_WIDTH = 64,
  localparam int DATA_WIDTH      = PIECES * BRAM_WIDTH,
  localparam int D_SIZE          = $clog2(ADDRS),
  localparam int PIECE_ADDR_SIZE = $clog2(PIECES),
  localparam int LOG_BRAM_DEPTH  = $clog2(ADDRS * PIECES)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [D_SIZE-1:0]         cpu_addr_in,
  input  logic [DATA_WIDTH-1:0]     cpu_data_in,
  input  logic                      cpu_valid_in,
  output logic                      cpu_ready_out,
  output logic                      cpu_done_out,
  output logic                      cpu_err_out,
  output logic [LOG_BRAM_DEPTH-1:0] bram_addr_out,
  output logic [BRAM_WIDTH-1:0]     bram_din_out,
  output logic                      bram_we_out
);

  // Keeps the counter at least one bit wide for the degenerate PIECES=1 case.
  localparam int PW = (PIECE_ADDR_SIZE > 0) ? PIECE_ADDR_SIZE : 1;

  medium_wr_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [LOG_BRAM_DEPTH-1:0] base_q, base_d;
  logic [PW-1:0]             piece_q, piece_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      base_q  <= '0;
      piece_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      base_q  <= base_d;
      piece_q <= piece_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    base_d  = base_q;
    piece_d = piece_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_valid_in) begin
          // Out-of-range words are consumed and flagged rather than stalling the CPU.
          if (32'(cpu_addr_in) >= 32'(ADDRS)) begin
            err_d = 1'b1;
          end else begin
            shift_d = cpu_data_in;
            base_d  = LOG_BRAM_DEPTH'(piece_addr(32'(cpu_addr_in), 32'(PIECES), 32'd0));
            piece_d = '0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        shift_d = shift_q << BRAM_WIDTH;
        piece_d = piece_q + PW'(1);
        if (piece_q == PW'(PIECES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // BRAM port is driven from registers only; it reads as zero while idle.
  assign bram_we_out   = (state_q == WRITE);
  assign bram_addr_out = bram_we_out ? base_q + LOG_BRAM_DEPTH'(piece_q) : '0;
  assign bram_din_out  = bram_we_out ? shift_q[DATA_WIDTH-1 -: BRAM_WIDTH] : '0;
  assign cpu_ready_out = (state_q == IDLE);
  assign cpu_done_out  = done_q;
  assign cpu_err_out   = err_q;

endmodule
